// File: rtl/core_start_sequencer_if.sv
// Host and core signal bundle for core_start_sequencer.
// master = sequencer side, slave = host/core environment side.
interface core_start_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                        host_wr_en;
  logic [ADDR_WIDTH-1:0]       host_wr_addr;
  logic [DATA_WIDTH-1:0]       host_wr_data;
  logic                        host_go;
  logic [ADDR_WIDTH-1:0]       host_rd_addr;
  logic [DATA_WIDTH-1:0]       host_rd_data;
  logic                        host_busy;
  logic                        host_result_valid;
  logic                        host_err_timeout;
  logic                        core_start;
  logic                        core_busy;
  logic                        core_done;
  logic [DATA_WIDTH*DEPTH-1:0] core_in_flat;
  logic [DATA_WIDTH*DEPTH-1:0] core_out_flat;

  modport master (
    input  host_wr_en, host_wr_addr, host_wr_data,
    input  host_go, host_rd_addr,
    output host_rd_data, host_busy,
    output host_result_valid, host_err_timeout,
    output core_start, core_in_flat,
    input  core_busy, core_done, core_out_flat
  );

  modport slave (
    output host_wr_en, host_wr_addr, host_wr_data,
    output host_go, host_rd_addr,
    input  host_rd_data, host_busy,
    input  host_result_valid, host_err_timeout,
    input  core_start, core_in_flat,
    output core_busy, core_done, core_out_flat
  );
endinterface

// File: rtl/core_start_sequencer.sv
// Host-side start/busy/done initiator with operand and result buffers.
// Optional core_done watchdog enabled by defining CORE_TIMEOUT_EN.
module core_start_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst,
  core_start_sequencer_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    WAIT_CLR
  } state_t;

  state_t state_q, state_d;
  logic start_q, start_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] in_q  [DEPTH];
  logic [DATA_WIDTH-1:0] in_d  [DEPTH];
  logic [DATA_WIDTH-1:0] res_q [DEPTH];
  logic [DATA_WIDTH-1:0] res_d [DEPTH];
  logic wr_ok;
  logic rd_ok;
  logic unused_busy;

`ifdef CORE_TIMEOUT_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`else
  logic [CW-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

  assign unused_busy = bus.core_busy;

  assign wr_ok = (state_q == IDLE) && bus.host_wr_en &&
                 (32'(bus.host_wr_addr) < DEPTH);
  assign rd_ok = 32'(bus.host_rd_addr) < DEPTH;

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    in_d      = in_q;
    res_d     = res_q;
    rd_data_d = rd_ok ? res_q[bus.host_rd_addr] : '0;
`ifdef CORE_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    if (wr_ok) begin
      in_d[bus.host_wr_addr] = bus.host_wr_data;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.host_go) begin
          start_d = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = WAIT_DONE;
`ifdef CORE_TIMEOUT_EN
          err_d   = 1'b0;
          cnt_d   = '0;
`endif
        end
      end
      WAIT_DONE: begin
        // A done level already high here is taken as this run's done.
        if (bus.core_done) begin
          for (int i = 0; i < DEPTH; i++) begin
            res_d[i] = bus.core_out_flat[i*DATA_WIDTH +: DATA_WIDTH];
          end
          start_d = 1'b0;
          state_d = WAIT_CLR;
`ifdef CORE_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          start_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      WAIT_CLR: begin
        if (!bus.core_done) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        in_q[i]  <= '0;
        res_q[i] <= '0;
      end
`ifdef CORE_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
      in_q      <= in_d;
      res_q     <= res_d;
`ifdef CORE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign bus.core_in_flat[g*DATA_WIDTH +: DATA_WIDTH] = in_q[g];
  end

  assign bus.core_start        = start_q;
  assign bus.host_busy         = busy_q;
  assign bus.host_result_valid = valid_q;
  assign bus.host_rd_data      = rd_data_q;
`ifdef CORE_TIMEOUT_EN
  assign bus.host_err_timeout  = err_q;
`else
  assign bus.host_err_timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_core_start_sequencer.sv
// Scoreboard bench for core_start_sequencer (DEPTH=32 and DEPTH=24).
// Expectations are queued with a due cycle; a negedge monitor checks them.
module tb_core_start_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D1 = 32;
  localparam int D2 = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_start_sequencer_if #(.DATA_WIDTH(DW), .DEPTH(D1), .ADDR_WIDTH(AW)) bus ();
  core_start_sequencer_if #(.DATA_WIDTH(DW), .DEPTH(D2), .ADDR_WIDTH(AW)) bus2 ();

  core_start_sequencer #(
    .DATA_WIDTH(DW), .DEPTH(D1), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  core_start_sequencer #(
    .DATA_WIDTH(DW), .DEPTH(D2), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.core_done     = bus2.core_start;
  assign bus2.core_busy     = bus2.core_start;
  assign bus2.core_out_flat = bus2.core_in_flat;
  assign bus.core_busy      = bus.core_start & ~bus.core_done;

  bit mode_done   = 1'b1;
  int hold_cycles = 0;
  int lat_cnt     = 0;
  int hold_cnt    = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.core_done     <= 1'b0;
      bus.core_out_flat <= '0;
      lat_cnt           <= 0;
      hold_cnt          <= 0;
    end else if (!bus.core_start) begin
      lat_cnt <= 0;
      if (bus.core_done) begin
        if (hold_cnt >= hold_cycles) bus.core_done <= 1'b0;
        else hold_cnt <= hold_cnt + 1;
      end
    end else if (!bus.core_done && mode_done) begin
      if (lat_cnt == 7) begin
        bus.core_done     <= 1'b1;
        bus.core_out_flat <= bus.core_in_flat;
        hold_cnt          <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rises = 0;
  always @(posedge bus.core_start) rises++;

  typedef struct {
    int          due;
    int          sel;
    int          idx;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_at(input int sel, input int idx,
                           input logic [31:0] exp, input int dly,
                           input string name);
    item_t it;
    it.due  = cyc + dly;
    it.sel  = sel;
    it.idx  = idx;
    it.exp  = exp;
    it.name = name;
    sbq.push_back(it);
  endtask

  function automatic logic [31:0] observe(input int sel, input int idx);
    case (sel)
      0: return bus.host_rd_data;
      1: return 32'(bus.host_busy);
      2: return 32'(bus.host_result_valid);
      3: return 32'(bus.host_err_timeout);
      4: return 32'(bus.core_start);
      5: return bus.core_in_flat[idx*DW +: DW];
      6: return bus2.host_rd_data;
      7: return bus2.core_in_flat[idx*DW +: DW];
      8: return 32'(rises);
      9: return 32'(bus2.host_result_valid);
      default: return 'x;
    endcase
  endfunction

  logic [31:0] act;
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        act = observe(sbq[i].sel, sbq[i].idx);
        n_cmp++;
        if (act !== sbq[i].exp) begin
          n_bad++;
          $display("FAIL %s: got %h want %h (cycle %0d)",
                   sbq[i].name, act, sbq[i].exp, cyc);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.host_wr_en   = 1'b1;
    bus.host_wr_addr = AW'(a);
    bus.host_wr_data = d;
    tick();
    bus.host_wr_en   = 1'b0;
  endtask

  task automatic wr2(input int a, input logic [31:0] d);
    bus2.host_wr_en   = 1'b1;
    bus2.host_wr_addr = AW'(a);
    bus2.host_wr_data = d;
    tick();
    bus2.host_wr_en   = 1'b0;
  endtask

  task automatic go();
    bus.host_go = 1'b1;
    tick();
    bus.host_go = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int k;
    k = 0;
    while (!bus.host_result_valid && k < max) begin
      tick();
      k++;
    end
    expect_at(2, 0, 1, 0, "valid_by_deadline");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.host_wr_en    = 1'b0;
    bus.host_wr_addr  = '0;
    bus.host_wr_data  = '0;
    bus.host_go       = 1'b0;
    bus.host_rd_addr  = '0;
    bus2.host_wr_en   = 1'b0;
    bus2.host_wr_addr = '0;
    bus2.host_wr_data = '0;
    bus2.host_go      = 1'b0;
    bus2.host_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.core_start !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_rst_start: got %b", bus.core_start);
    end

    expect_at(1, 0, 0, 0, "rst_busy");
    expect_at(2, 0, 0, 0, "rst_valid");
    expect_at(3, 0, 0, 0, "rst_err");
    expect_at(4, 0, 0, 0, "rst_start");
    expect_at(0, 0, 0, 0, "rst_rd_data");

    for (int i = 0; i < 31; i++) wr(i, 32'hA500_0000 + i);
    bus.host_wr_en   = 1'b1;
    bus.host_wr_addr = 5'd31;
    bus.host_wr_data = 32'hA500_001F;
    bus.host_go      = 1'b1;
    tick();
    bus.host_wr_en   = 1'b0;
    bus.host_go      = 1'b0;
    expect_at(4, 0, 1, 0, "start_after_go");
    expect_at(1, 0, 1, 0, "busy_after_go");
    expect_at(2, 0, 0, 0, "valid_cleared");
    expect_at(5, 31, 32'hA500_001F, 0, "in_w31_with_go");

    tick();
    bus.host_wr_en   = 1'b1;
    bus.host_wr_addr = 5'd3;
    bus.host_wr_data = 32'h0000_DEAD;
    bus.host_go      = 1'b1;
    tick();
    bus.host_wr_en   = 1'b0;
    bus.host_go      = 1'b0;
    tick();
    expect_at(5, 3, 32'hA500_0003, 0, "in_w3_blocked");
    expect_at(1, 0, 1, 0, "busy_mid_run");

    wait_valid(16);
    n_cmp++;
    if (bus.host_result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_valid: got %b", bus.host_result_valid);
    end
    n_cmp++;
    if (bus.core_start !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_start_low: got %b", bus.core_start);
    end
    expect_at(4, 0, 0, 0, "start_low_at_valid");
    expect_at(1, 0, 0, 0, "busy_low_at_valid");
    bus.host_rd_addr = 5'd7;
    expect_at(0, 0, 32'hA500_0007, 1, "rd_w7");
    tick();
    bus.host_rd_addr = 5'd31;
    expect_at(0, 0, 32'hA500_001F, 1, "rd_w31");
    tick();
    bus.host_rd_addr = 5'd3;
    expect_at(0, 0, 32'hA500_0003, 1, "rd_w3");
    tick();
    expect_at(8, 0, 1, 0, "one_start_rise");

    hold_cycles = 5;
    wr(0, 32'h0000_0011);
    go();
    k = 0;
    while (bus.core_start && k < 20) begin
      tick();
      k++;
    end
    expect_at(4, 0, 0, 0, "start_fell");
    k = 0;
    while (bus.core_done && k < 20) begin
      expect_at(1, 0, 1, 0, "busy_while_done");
      expect_at(2, 0, 0, 0, "novalid_while_done");
      tick();
      k++;
    end
    expect_at(1, 0, 1, 0, "busy_at_done_fall");
    expect_at(2, 0, 0, 0, "novalid_at_done_fall");
    expect_at(2, 0, 1, 1, "valid_after_done_fall");
    expect_at(1, 0, 0, 1, "idle_after_done_fall");
    bus.host_rd_addr = 5'd0;
    expect_at(0, 0, 32'h0000_0011, 1, "rd_w0_run2");
    tick();
    tick();
    hold_cycles = 0;

    mode_done = 1'b0;
    go();
    expect_at(4, 0, 1, 0, "start_before_rst");
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.core_start !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_async_drop: got %b", bus.core_start);
    end
    expect_at(4, 0, 0, 0, "start_async_drop");
    expect_at(1, 0, 0, 0, "busy_async_drop");
    expect_at(2, 0, 0, 0, "valid_async_drop");
    expect_at(3, 0, 0, 0, "err_async_drop");
    @(posedge clk);
    #1 rst = 1'b0;
    mode_done = 1'b1;
    bus.host_rd_addr = 5'd7;
    expect_at(0, 0, 0, 1, "rd_after_rst");
    expect_at(5, 31, 0, 0, "in_cleared_rst");
    tick();
    tick();

`ifdef CORE_TIMEOUT_EN
    mode_done = 1'b0;
    go();
    expect_at(4, 0, 1, 15, "start_before_tmo");
    expect_at(4, 0, 0, 16, "start_drop_tmo");
    expect_at(3, 0, 1, 16, "err_tmo");
    expect_at(2, 0, 0, 16, "novalid_tmo");
    expect_at(1, 0, 0, 16, "nobusy_tmo");
    repeat (18) tick();
    mode_done = 1'b1;
    go();
    expect_at(3, 0, 0, 0, "err_cleared_go");
    expect_at(4, 0, 1, 0, "start_after_tmo");
    wait_valid(16);
    expect_at(3, 0, 0, 0, "err_after_ok_run");
`else
    mode_done = 1'b0;
    go();
    repeat (20) tick();
    expect_at(4, 0, 1, 0, "start_waits");
    expect_at(3, 0, 0, 0, "err_tied_low");
    expect_at(1, 0, 1, 0, "busy_waits");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode_done = 1'b1;
`endif
    tick();

    wr2(23, 32'h0000_2323);
    wr2(30, 32'h0000_3030);
    expect_at(7, 23, 32'h0000_2323, 0, "d24_w23");
    expect_at(7, 6, 0, 0, "d24_w30_dropped");
    bus2.host_go = 1'b1;
    tick();
    bus2.host_go = 1'b0;
    k = 0;
    while (!bus2.host_result_valid && k < 8) begin
      tick();
      k++;
    end
    expect_at(9, 0, 1, 0, "d24_valid");
    bus2.host_rd_addr = 5'd23;
    expect_at(6, 0, 32'h0000_2323, 1, "d24_rd_w23");
    tick();
    bus2.host_rd_addr = 5'd30;
    expect_at(6, 0, 0, 1, "d24_rd_w30");
    tick();

    repeat (3) tick();
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL too few comparisons: %0d", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/core_start_sequencer.md
Name: core_start_sequencer

Overview:
- Host-side initiator for the user-core start/busy/done handshake.
- Takes operand words from a host write port into a local input buffer and presents them flattened to the core.
- On a host go pulse, raises core_start and waits for core_done. It then captures the core's output buffer, drops core_start, and waits for core_done to clear.
- Presents captured results on a host read port, together with status flags.
- Sits between the AXI-Lite register slice and any user core that follows the start/busy/done protocol.

Parameters:
- DATA_WIDTH, 32, width of one buffer word.
- DEPTH, 32, words per buffer.
- ADDR_WIDTH, 5, host word-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for core_done (used only with CORE_TIMEOUT_EN).

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- host_wr_en, input, 1, write operand word.
- host_wr_addr, input, ADDR_WIDTH, operand word index.
- host_wr_data, input, DATA_WIDTH, operand word.
- host_go, input, 1, single-cycle request to run the core.
- host_rd_addr, input, ADDR_WIDTH, result word index.
- host_rd_data, output, DATA_WIDTH, result word, registered.
- host_busy, output, 1, sequence in progress.
- host_result_valid, output, 1, result buffer holds a completed run.
- host_err_timeout, output, 1, last run timed out (sticky).
- core_start, output, 1, start level to the core.
- core_busy, input, 1, core busy (status only; no decision depends on it).
- core_done, input, 1, core done level.
- core_in_flat, output, DATA_WIDTH*DEPTH, input buffer; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- core_out_flat, input, DATA_WIDTH*DEPTH, core output buffer, same packing.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE; core_start 0; host_busy 0; host_result_valid 0; host_err_timeout 0; host_rd_data 0. Both buffers are cleared to 0. Reset mid-sequence aborts immediately and core_start drops asynchronously.
- Operand writes: accepted only in IDLE, with host_wr_addr < DEPTH. Otherwise silently dropped.
- Result reads: host_rd_data updates one cycle after host_rd_addr. Out-of-range addresses return 0. Reads are allowed in any state and return the last captured buffer.
- States:
  - IDLE: host_go=1 -> core_start<=1, host_busy<=1, host_result_valid<=0, host_err_timeout<=0, timeout counter<=0, go to WAIT_DONE. host_go in any other state is ignored. host_go and host_wr_en in the same IDLE cycle: the write is committed, and core_in_flat reflects it from the next cycle, i.e. by the time core_start is seen high.
  - WAIT_DONE: core_done=1 -> result buffer<=core_out_flat (whole buffer, one cycle), core_start<=0, go to WAIT_CLR. Otherwise the counter increments.
  - WAIT_CLR: core_done=0 -> host_busy<=0, host_result_valid<=1, go to IDLE.
- core_done already high on entry to WAIT_DONE (stale from a previous run) is not distinguished from a fresh done; it is captured anyway. The protocol guarantees done clears during WAIT_CLR before the next run.
- Latency: core_start rises on the edge after host_go. Capture and core_start fall occur on the first edge with core_done=1. host_result_valid rises on the first edge with core_done=0 after that.
- core_in_flat is a continuous view of the input buffer and is stable throughout a run, because writes are blocked while busy.

Optional Feature:
- Macro: CORE_TIMEOUT_EN.
- Defined:
  - In WAIT_DONE, when the counter reaches TIMEOUT_CYCLES-1 without core_done: core_start<=0, host_err_timeout<=1, host_busy<=0, go to IDLE.
  - host_result_valid stays 0 and the result buffer is unchanged.
  - The counter is sized $clog2(TIMEOUT_CYCLES+1).
  - If core_done and the terminal count occur in the same cycle, done wins and the run completes normally.
- Undefined: no counter; WAIT_DONE waits indefinitely; host_err_timeout is tied to 0.

Test Plan:
- Reset: assert rst mid-WAIT_DONE -> core_start falls without a clock edge; all flags 0; host_rd_data 0 after release.
- Basic run: write words i=0..31 with value 32'hA5000000+i, pulse go, connect an 8-cycle-latency pass-through core -> host_result_valid=1 within 16 cycles; reading addr 7 gives 32'hA5000007 one cycle later; core_start is 0 when valid.
- Blocked access: host_wr_en to addr 3 with 32'hDEAD while busy, and a second host_go while busy -> core_in_flat word 3 unchanged; exactly one core_start rising edge.
- Boundaries: write to addr 31 works; with DEPTH=24, a write to addr 30 is dropped and a read of addr 30 returns 0.
- Done handshake: core holds done high 5 cycles after start falls -> host_busy stays 1 until done falls; host_result_valid then rises the next edge.
- Timeout (CORE_TIMEOUT_EN, TIMEOUT_CYCLES=16): core never asserts done -> core_start drops and host_err_timeout=1 after 16 cycles in WAIT_DONE; host_result_valid=0; a new go clears the error.
